axis_video_tpg: RTL and testbench

AXI-Stream video master that generates synthetic RGB frames on the same 24-bit {B,G,R} video protocol the JPEG encoder accepts. It drives tuser on start of frame and tlast on end of line, and inserts programmable blanking. It honours tready backpressure. It is the stimulus source for encoder bring-up on FPGA, and it is the replacement for the sensor in loopback tests.

---
 rtl/jtpg_pkg.sv | 24 ++
 rtl/jtpg_pixel.sv | 30 +++
 rtl/axis_video_tpg.sv | 186 ++++++++++++++++++
 tb/tb_axis_video_tpg.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtpg_pkg.sv
// Shared types and constants for the AXI-Stream video test pattern generator.
package jtpg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } tpg_state_e;

  typedef enum logic [1:0] {
    PAT_GRAY,
    PAT_RAMP,
    PAT_BARS,
    PAT_CHECK
  } tpg_pat_e;

  // Colour bars as {B,G,R}, indexed by x[7:5]
  localparam logic [23:0] BAR_LUT [0:7] = '{
    24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
    24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000
  };

endpackage

// File: rtl/jtpg_pixel.sv
// Combinational pattern generator: pixel coordinates and frame parity to a {B,G,R} pixel.
module jtpg_pixel
  import jtpg_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [7:0]      i_x,
  input  logic [7:0]      i_y,
  input  logic [1:0]      i_pattern,
  input  logic            i_fcnt_lsb,
  output logic [3*DW-1:0] o_pixel
);

  logic [23:0] w_rgb;

  always_comb begin
    w_rgb = 24'h808080;
    case (tpg_pat_e'(i_pattern))
      PAT_GRAY:  w_rgb = 24'h808080;
      PAT_RAMP:  w_rgb = {i_x ^ i_y, i_y, i_x};
      PAT_BARS:  w_rgb = BAR_LUT[i_x[7:5]];
      PAT_CHECK: w_rgb = (i_x[3] ^ i_y[3] ^ i_fcnt_lsb) ? 24'hFFFFFF : 24'h000000;
      default:   w_rgb = 24'h808080;
    endcase
  end

  // Each 8-bit component sits in the LSBs of its DW-wide lane
  assign o_pixel = {DW'(w_rgb[23:16]), DW'(w_rgb[15:8]), DW'(w_rgb[7:0])};

endmodule

// File: rtl/axis_video_tpg.sv
// AXI-Stream video master producing synthetic {B,G,R} frames with programmable blanking.
// State table: IDLE waiting for start/continuous | ACTIVE streaming a line | HBLANK gap after a line | VBLANK gap after a frame
module axis_video_tpg
  import jtpg_pkg::*;
#(
  parameter int DW            = 8,
  parameter int SENSOR_X_SIZE = 720,
  parameter int SENSOR_Y_SIZE = 720,
  parameter int HBLANK        = 16,
  parameter int VBLANK        = 64
) (
  input  logic                             pixel_clock,
  input  logic                             pixel_reset,
  input  logic                             start,
  input  logic                             continuous,
  input  logic [1:0]                       pattern,
  input  logic [$clog2(SENSOR_X_SIZE)-1:0] x_size_m1,
  input  logic [$clog2(SENSOR_Y_SIZE)-1:0] y_size_m1,
  output logic [3*DW-1:0]                  m_axis_video_tdata,
  output logic                             m_axis_video_tvalid,
  input  logic                             m_axis_video_tready,
  output logic                             m_axis_video_tuser,
  output logic                             m_axis_video_tlast,
  output logic                             busy,
  output logic                             frame_done,
  output logic [7:0]                       frame_cnt
);

  localparam int XW = $clog2(SENSOR_X_SIZE);
  localparam int YW = $clog2(SENSOR_Y_SIZE);
  localparam int CW = 16;
  localparam logic [XW-1:0] X_MAX   = XW'(SENSOR_X_SIZE - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(SENSOR_Y_SIZE - 1);
  localparam logic [CW-1:0] HB_LOAD = CW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [CW-1:0] VB_LOAD = CW'((VBLANK > 0) ? VBLANK - 1 : 0);

  tpg_state_e      r_state, w_state_nx;
  logic [XW-1:0]   r_x, r_xlat, w_xlat_in, w_px_x;
  logic [YW-1:0]   r_y, r_ylat, w_ylat_in, w_px_y;
  logic [1:0]      r_pat, w_px_pat;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_frame_cnt;
  logic            r_start_pend, r_tvalid, r_tuser, r_tlast, r_frame_done;
  logic [3*DW-1:0] r_tdata, w_pixel;
  logic            w_accept, w_eol, w_eof, w_go, w_cnt_zero, w_fcnt_lsb, w_tlast_nx;
  logic            w_new_frame, w_new_line, w_next_pix, w_load;

  assign w_xlat_in  = (x_size_m1 > X_MAX) ? X_MAX : x_size_m1;
  assign w_ylat_in  = (y_size_m1 > Y_MAX) ? Y_MAX : y_size_m1;
  assign w_accept   = r_tvalid & m_axis_video_tready;
  assign w_eol      = w_accept & (r_x == r_xlat);
  assign w_eof      = w_eol & (r_y == r_ylat);
  assign w_go       = continuous | r_start_pend | start;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge pixel_clock or posedge pixel_reset) begin
    if (pixel_reset) r_state <= ST_IDLE;
    else             r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_new_frame = 1'b0;
    w_new_line  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start | continuous) begin
          w_state_nx  = ST_ACTIVE;
          w_new_frame = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_eof) begin
          if (VBLANK > 0)  w_state_nx = ST_VBLANK;
          else if (w_go)   w_new_frame = 1'b1;
          else             w_state_nx = ST_IDLE;
        end else if (w_eol) begin
          if (HBLANK > 0)  w_state_nx = ST_HBLANK;
          else             w_new_line = 1'b1;
        end
      end
      ST_HBLANK: begin
        if (w_cnt_zero) begin
          w_state_nx = ST_ACTIVE;
          w_new_line = 1'b1;
        end
      end
      ST_VBLANK: begin
        if (w_cnt_zero) begin
          if (w_go) begin
            w_state_nx  = ST_ACTIVE;
            w_new_frame = 1'b1;
          end else begin
            w_state_nx  = ST_IDLE;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Coordinates of the beat about to be loaded into the output register
  always_comb begin
    busy       = (r_state != ST_IDLE);
    w_next_pix = w_accept & ~w_eol;
    w_load     = w_new_frame | w_new_line | w_next_pix;
    w_fcnt_lsb = r_frame_cnt[0] ^ w_eof;
    w_px_pat   = w_new_frame ? pattern : r_pat;
    w_px_x     = w_next_pix ? r_x + 1'b1 : '0;
    if (w_new_frame)  w_px_y = '0;
    else if (w_eol)   w_px_y = r_y + 1'b1;
    else              w_px_y = r_y;
    w_tlast_nx = (w_px_x == (w_new_frame ? w_xlat_in : r_xlat));
  end

  jtpg_pixel #(.DW(DW)) u_pixel (
    .i_x        (8'(w_px_x)),
    .i_y        (8'(w_px_y)),
    .i_pattern  (w_px_pat),
    .i_fcnt_lsb (w_fcnt_lsb),
    .o_pixel    (w_pixel)
  );

  always_ff @(posedge pixel_clock or posedge pixel_reset) begin
    if (pixel_reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_xlat       <= '0;
      r_ylat       <= '0;
      r_pat        <= '0;
      r_cnt        <= '0;
      r_frame_cnt  <= '0;
      r_start_pend <= 1'b0;
      r_frame_done <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tuser      <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdata      <= '0;
    end else begin
      r_frame_done <= w_eof;
      if (w_eof) r_frame_cnt <= r_frame_cnt + 8'd1;

      if (w_new_frame) begin
        r_pat        <= pattern;
        r_xlat       <= w_xlat_in;
        r_ylat       <= w_ylat_in;
        r_start_pend <= 1'b0;
      end else if (start && r_state != ST_IDLE) begin
        r_start_pend <= 1'b1;
      end

      if (w_new_frame) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_next_pix) begin
        r_x <= r_x + 1'b1;
      end else if (w_eol) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end

      if (w_eof)            r_cnt <= VB_LOAD;
      else if (w_eol)       r_cnt <= HB_LOAD;
      else if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;

      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_pixel;
        r_tuser  <= w_new_frame;
        r_tlast  <= w_tlast_nx;
      end else if (w_accept) begin
        r_tvalid <= 1'b0;
        r_tuser  <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

  assign m_axis_video_tdata  = r_tdata;
  assign m_axis_video_tvalid = r_tvalid;
  assign m_axis_video_tuser  = r_tuser;
  assign m_axis_video_tlast  = r_tlast;
  assign frame_done          = r_frame_done;
  assign frame_cnt           = r_frame_cnt;

endmodule

// File: tb/tb_axis_video_tpg.sv
// Scoreboard bench for axis_video_tpg: stimulus queues expected beats, a negedge monitor checks them.
module tb_axis_video_tpg;

  localparam int HB = 16;
  localparam int VB = 64;

  logic        pixel_clock = 1'b0;
  logic        pixel_reset = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [9:0]  x_size_m1 = 10'd0;
  logic [9:0]  y_size_m1 = 10'd0;
  logic [23:0] tdata;
  logic        tvalid, tuser, tlast, busy, frame_done;
  logic        tready = 1'b0;
  logic [7:0]  frame_cnt;

  always #5 pixel_clock = ~pixel_clock;

  axis_video_tpg dut (
    .pixel_clock         (pixel_clock),
    .pixel_reset         (pixel_reset),
    .start               (start),
    .continuous          (continuous),
    .pattern             (pattern),
    .x_size_m1           (x_size_m1),
    .y_size_m1           (y_size_m1),
    .m_axis_video_tdata  (tdata),
    .m_axis_video_tvalid (tvalid),
    .m_axis_video_tready (tready),
    .m_axis_video_tuser  (tuser),
    .m_axis_video_tlast  (tlast),
    .busy                (busy),
    .frame_done          (frame_done),
    .frame_cnt           (frame_cnt)
  );

  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
    logic        eof;
    int          x;
    int          y;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] cap_first[$];
  logic [23:0] cap_32 = 24'd0;
  logic [23:0] cap_x32 = 24'd0;
  logic        rand_rdy = 1'b0;
  int n_checks = 0, n_errors = 0;
  int fd_pulses = 0, n_beats = 0, line_len = 0, last_line_len = 0, gap_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model_pix(input int pat, input int x, input int y, input int fc);
    logic [7:0] x8, y8;
    x8 = x[7:0];
    y8 = y[7:0];
    case (pat)
      0: return 24'h808080;
      1: return {x8 ^ y8, y8, x8};
      2: case (x8[7:5])
           3'd0: return 24'hFFFFFF;
           3'd1: return 24'h00FFFF;
           3'd2: return 24'hFFFF00;
           3'd3: return 24'h00FF00;
           3'd4: return 24'hFF00FF;
           3'd5: return 24'h0000FF;
           3'd6: return 24'hFF0000;
           default: return 24'h000000;
         endcase
      default: return (x8[3] ^ y8[3] ^ fc[0]) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic push_frame(input int pat, input int xlat, input int ylat, input int fc, input int first_gap);
    exp_t e;
    for (int y = 0; y <= ylat; y++) begin
      for (int x = 0; x <= xlat; x++) begin
        e.data = model_pix(pat, x, y, fc);
        e.user = (x == 0 && y == 0);
        e.last = (x == xlat);
        e.eof  = (x == xlat && y == ylat);
        e.x    = x;
        e.y    = y;
        e.gap  = (x != 0) ? -2 : ((y == 0) ? first_gap : HB);
        sb.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
    if (rand_rdy) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (frame_done) break;
    end
    if (!frame_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_done_timeout: got no pulse expected pulse within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  // Monitor: samples on the falling edge, a beat is accepted at the next rising edge
  initial begin
    exp_t        e;
    logic        prev_stall = 1'b0, prev_eof = 1'b0;
    logic [25:0] stall_beat = '0;
    forever begin
      @(negedge pixel_clock);
      if (pixel_reset) begin
        prev_stall = 1'b0;
        prev_eof   = 1'b0;
        gap_cnt    = 0;
        line_len   = 0;
      end else begin
        if (prev_eof || frame_done) chk("frame_done", 32'(frame_done), 32'(prev_eof));
        if (frame_done) fd_pulses++;
        prev_eof = 1'b0;
        if (prev_stall) begin
          chk("stall_tvalid", 32'(tvalid), 32'd1);
          chk("stall_beat", 32'({tuser, tlast, tdata}), 32'(stall_beat));
        end
        prev_stall = tvalid & ~tready;
        stall_beat = {tuser, tlast, tdata};
        if (!tvalid) gap_cnt++;
        if (tvalid && tready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got %h expected no beat", {tuser, tlast, tdata});
          end else begin
            e = sb.pop_front();
            chk("beat", 32'({tuser, tlast, tdata}), 32'({e.user, e.last, e.data}));
            if (e.gap >= 0) chk("gap", 32'(gap_cnt), 32'(e.gap));
            if (e.x == 3 && e.y == 2) cap_32 = tdata;
            if (e.x == 32 && e.y == 0) cap_x32 = tdata;
            prev_eof = e.eof;
          end
          if (tuser) cap_first.push_back(tdata);
          n_beats++;
          line_len++;
          if (tlast) begin
            last_line_len = line_len;
            line_len = 0;
            gap_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f0, b0;
    logic [23:0] exp_first [3];
    exp_first[0] = 24'h000000;
    exp_first[1] = 24'hFFFFFF;
    exp_first[2] = 24'h000000;

    // Reset state
    repeat (3) tick();
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_tuser", 32'(tuser), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    pixel_reset = 1'b0;
    tready = 1'b1;
    repeat (4) tick();
    chk("idle_after_release", 32'({busy, tvalid}), 32'd0);

    // Continuous mode, checker pattern
    pattern = 2'd3; x_size_m1 = 10'd15; y_size_m1 = 10'd3;
    push_frame(3, 15, 3, 0, -1);
    push_frame(3, 15, 3, 1, VB);
    push_frame(3, 15, 3, 2, VB);
    cap_first.delete();
    continuous = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_fd(2000);
      chk("cont_frame_cnt", 32'(frame_cnt), 32'(f + 1));
      if (f == 1) begin
        n = 0;
        while (!tvalid && n < 500) begin tick(); n++; end
        chk("cont_frame2_start", 32'(tvalid), 32'd1);
        continuous = 1'b0;
      end
    end
    wait_idle(n);
    chk("cont_first_count", 32'(cap_first.size()), 32'd3);
    for (int i = 0; i < 3 && i < cap_first.size(); i++)
      chk("cont_pixel_0_0", 32'(cap_first[i]), 32'(exp_first[i]));
    chk("cont_queue_empty", 32'(sb.size()), 32'd0);

    // Basic frame, ramp pattern
    pattern = 2'd1; x_size_m1 = 10'd15; y_size_m1 = 10'd15;
    f0 = fd_pulses; b0 = n_beats;
    push_frame(1, 15, 15, 3, -1);
    pulse_start();
    chk("tvalid_after_start", 32'(tvalid), 32'd1);
    wait_fd(2000);
    chk("basic_frame_cnt", 32'(frame_cnt), 32'd4);
    n = 0;
    while (busy && n < 1000) begin n++; tick(); end
    chk("basic_vblank_to_idle", 32'(n), 32'(VB));
    chk("basic_beats", 32'(n_beats - b0), 32'd256);
    chk("basic_frame_done_once", 32'(fd_pulses - f0), 32'd1);
    chk("basic_px_3_2", 32'(cap_32), 32'h010203);
    chk("basic_queue_empty", 32'(sb.size()), 32'd0);

    // Backpressure, same frame with random tready
    b0 = n_beats;
    push_frame(1, 15, 15, 4, -1);
    rand_rdy = 1'b1;
    pulse_start();
    wait_fd(4000);
    rand_rdy = 1'b0;
    tready = 1'b1;
    wait_idle(n);
    chk("bp_beats", 32'(n_beats - b0), 32'd256);
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("bp_queue_empty", 32'(sb.size()), 32'd0);

    // Start pending: three extra pulses during one frame give one extra frame
    pattern = 2'd0; x_size_m1 = 10'd7; y_size_m1 = 10'd1;
    f0 = fd_pulses; b0 = n_beats;
    push_frame(0, 7, 1, 5, -1);
    push_frame(0, 7, 1, 6, VB);
    pulse_start();
    repeat (3) tick();
    pulse_start();
    repeat (2) tick();
    pulse_start();
    tick();
    pulse_start();
    wait_idle(n);
    repeat (100) tick();
    chk("pend_frames", 32'(fd_pulses - f0), 32'd2);
    chk("pend_beats", 32'(n_beats - b0), 32'd32);
    chk("pend_idle", 32'(busy), 32'd0);
    chk("pend_frame_cnt", 32'(frame_cnt), 32'd7);

    // Clamping and mid-frame size change
    pattern = 2'd2; x_size_m1 = 10'd1023; y_size_m1 = 10'd1;
    push_frame(2, 719, 1, 7, -1);
    pulse_start();
    repeat (50) tick();
    x_size_m1 = 10'd99;
    pattern = 2'd0;
    wait_fd(5000);
    chk("clamp_line_len", 32'(last_line_len), 32'd720);
    chk("clamp_bar_x32", 32'(cap_x32), 32'h00FFFF);
    wait_idle(n);
    push_frame(0, 99, 1, 8, -1);
    pulse_start();
    wait_fd(2000);
    chk("resize_line_len", 32'(last_line_len), 32'd100);
    wait_idle(n);
    chk("clamp_queue_empty", 32'(sb.size()), 32'd0);

    // Reset mid-line while stalled at x=7
    pattern = 2'd1; x_size_m1 = 10'd15; y_size_m1 = 10'd3;
    tready = 1'b0;
    push_frame(1, 15, 3, 9, -1);
    pulse_start();
    chk("mid_tvalid", 32'(tvalid), 32'd1);
    tready = 1'b1;
    repeat (7) tick();
    tready = 1'b0;
    tick();
    chk("stall_at_x7", 32'(tdata), 32'h070007);
    pixel_reset = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(tvalid), 32'd0);
    chk("mid_rst_tdata", 32'(tdata), 32'd0);
    chk("mid_rst_tuser", 32'(tuser), 32'd0);
    chk("mid_rst_tlast", 32'(tlast), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    sb.delete();
    repeat (2) tick();
    pixel_reset = 1'b0;
    tready = 1'b1;
    n = 0;
    repeat (40) begin
      tick();
      if (tvalid || busy) n++;
    end
    chk("no_activity_after_reset", 32'(n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
